// File: rtl/wheel_odometer_if.sv
// Sensor-side and display-side signal bundle for wheel_odometer.
// The master modport drives the sensor inputs; the slave modport is the odometer itself.
interface wheel_odometer_if #(
   parameter int unsigned SPEED_W = 9,
   parameter int unsigned DIST_W  = 13
);
   logic               hall_in;
   logic               dist_clr;
   logic [SPEED_W-1:0] speed;
   logic               speed_valid;
   logic               moving;
   logic [DIST_W-1:0]  distance;
   logic               dist_sat;

   modport master (
      output hall_in, dist_clr,
      input  speed, speed_valid, moving, distance, dist_sat
   );

   modport slave (
      input  hall_in, dist_clr,
      output speed, speed_valid, moving, distance, dist_sat
   );
endinterface

// File: rtl/wheel_odometer.sv
// Wheel odometer: synchronised hall pulses -> windowed, smoothed speed and saturating distance.
// Optional hold-off debounce on accepted rises is built when ODO_DEBOUNCE_EN is defined.
module wheel_odometer #(
   parameter int unsigned WINDOW_CYC   = 100,
   parameter int unsigned SPEED_W      = 9,
   parameter int unsigned DIST_W       = 13,
   parameter int unsigned DIST_STEP    = 1,
   parameter int unsigned AVG_LOG2     = 2,
   parameter int unsigned DEBOUNCE_CYC = 3
) (
   input  logic             clk,
   input  logic             reset,
   wheel_odometer_if.slave  bus
);
   localparam int unsigned WT_W  = $clog2(WINDOW_CYC);
   localparam int unsigned DEPTH = 1 << AVG_LOG2;
   localparam int unsigned PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int unsigned SUM_W = SPEED_W + AVG_LOG2;

   localparam logic [SPEED_W-1:0] CNT_MAX    = '1;
   localparam logic [DIST_W-1:0]  DIST_MAX   = '1;
   localparam logic [DIST_W:0]    DIST_MAX_X = {1'b0, DIST_MAX};
   localparam logic [DIST_W:0]    STEP_X     = (DIST_W+1)'(DIST_STEP);

   if (WINDOW_CYC < 2 || DEBOUNCE_CYC >= 65536) begin : g_bad_param
      $error("wheel_odometer: WINDOW_CYC must be >= 2 and DEBOUNCE_CYC < 65536");
   end

   logic r_s1, r_s2, r_s3;
   logic w_rise, w_acc;

   logic [WT_W-1:0]    r_win_t;
   logic [SPEED_W-1:0] r_win_cnt;
   logic [SPEED_W-1:0] r_hist [DEPTH];
   logic [PTR_W-1:0]   r_ptr;
   logic [SUM_W-1:0]   r_sum;
   logic [SPEED_W-1:0] r_speed;
   logic               r_speed_valid;
   logic               r_moving;
   logic [DIST_W-1:0]  r_distance;
   logic               r_dist_sat;

   logic               w_close;
   logic [SPEED_W-1:0] w_cnt_inc, w_closed, w_oldest, w_speed_sat;
   logic [PTR_W-1:0]   w_ptr_next;
   logic [SUM_W-1:0]   w_sum_next;
   logic [DIST_W-1:0]  w_dist_base;
   logic [DIST_W:0]    w_dist_add;
   logic               w_dist_hit;

   // Two-flop synchroniser plus one history flop for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= bus.hall_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise = r_s2 & ~r_s3;

`ifdef ODO_DEBOUNCE_EN
   localparam int unsigned HOLD_W = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
   logic [HOLD_W-1:0] r_hold;

   assign w_acc = w_rise & (r_hold == '0);

   // Hold-off: ignored rises neither count nor reload the counter
   always_ff @(posedge clk) begin
      if (reset)                r_hold <= '0;
      else if (w_acc)           r_hold <= HOLD_W'(DEBOUNCE_CYC);
      else if (r_hold != '0)    r_hold <= r_hold - HOLD_W'(1);
   end
`else
   assign w_acc = w_rise;
`endif

   assign w_close     = (r_win_t == WT_W'(WINDOW_CYC - 1));
   assign w_cnt_inc   = (r_win_cnt == CNT_MAX) ? CNT_MAX : r_win_cnt + SPEED_W'(1);
   assign w_closed    = w_acc ? w_cnt_inc : r_win_cnt;
   assign w_oldest    = r_hist[r_ptr];
   assign w_ptr_next  = (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
   // Sum always contains the oldest entry, so the subtraction cannot underflow
   assign w_sum_next  = r_sum + SUM_W'(w_closed) - SUM_W'(w_oldest);
   assign w_speed_sat = (w_sum_next > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum_next[SPEED_W-1:0];

   // Window timer, per-window count and smoothing ring
   always_ff @(posedge clk) begin
      if (reset) begin
         r_win_t       <= '0;
         r_win_cnt     <= '0;
         r_ptr         <= '0;
         r_sum         <= '0;
         r_speed       <= '0;
         r_speed_valid <= 1'b0;
         r_moving      <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) r_hist[i] <= '0;
      end else begin
         r_speed_valid <= 1'b0;
         if (w_close) begin
            r_win_t        <= '0;
            r_win_cnt      <= '0;
            r_hist[r_ptr]  <= w_closed;
            r_ptr          <= w_ptr_next;
            r_sum          <= w_sum_next;
            r_speed        <= w_speed_sat;
            r_moving       <= (w_closed != '0);
            r_speed_valid  <= 1'b1;
         end else begin
            r_win_t   <= r_win_t + WT_W'(1);
            r_win_cnt <= w_closed;
         end
      end
   end

   // A clear coincident with a pulse clears first, then counts the pulse
   assign w_dist_base = bus.dist_clr ? '0 : r_distance;
   assign w_dist_add  = {1'b0, w_dist_base} + STEP_X;
   assign w_dist_hit  = (w_dist_add >= DIST_MAX_X);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_distance <= '0;
         r_dist_sat <= 1'b0;
      end else if (w_acc) begin
         r_distance <= w_dist_hit ? DIST_MAX : w_dist_add[DIST_W-1:0];
         r_dist_sat <= w_dist_hit | (r_dist_sat & ~bus.dist_clr);
      end else if (bus.dist_clr) begin
         r_distance <= '0;
         r_dist_sat <= 1'b0;
      end
   end

   assign bus.speed       = r_speed;
   assign bus.speed_valid = r_speed_valid;
   assign bus.moving      = r_moving;
   assign bus.distance    = r_distance;
   assign bus.dist_sat    = r_dist_sat;
endmodule

// File: tb/tb_wheel_odometer.sv
// Bench for wheel_odometer: per-cycle comparison against an edge-indexed behavioural model,
// directed scenarios with literal expectations, and a randomized hall/clear phase.
module tb_wheel_odometer;
   localparam int unsigned W         = 100;
   localparam int unsigned SPEED_W   = 9;
   localparam int unsigned DIST_W    = 13;
   localparam int unsigned DIST_STEP = 1;
   localparam int unsigned AVG_LOG2  = 2;
   localparam int unsigned DEB       = 3;
   localparam int NWIN     = 1 << AVG_LOG2;
   localparam int SPD_MAX  = (1 << SPEED_W) - 1;
   localparam int DIST_MAX = (1 << DIST_W) - 1;

   logic clk = 1'b0;
   logic reset;

   wheel_odometer_if #(.SPEED_W(SPEED_W), .DIST_W(DIST_W)) bus ();

   wheel_odometer #(
      .WINDOW_CYC(W), .SPEED_W(SPEED_W), .DIST_W(DIST_W), .DIST_STEP(DIST_STEP),
      .AVG_LOG2(AVG_LOG2), .DEBOUNCE_CYC(DEB)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the n-th edge since reset counts a pulse when the hall samples taken at edges
   // n-2 and n-3 were 1 and 0; windows are the edge ranges (k-1)*W+1 .. k*W.
   bit mdl_live = 1'b0;
   bit samp[$];
   int t, gap, wcnt;
   int hist[$];
   int e_speed, e_valid, e_moving, e_dist, e_sat;

   always @(posedge clk) begin
      bit rise, acc;
      int sum;
      if (reset) begin
         samp.delete();
         repeat (3) samp.push_back(1'b0);
         hist.delete();
         repeat (NWIN) hist.push_back(0);
         t = 0; gap = 1000; wcnt = 0;
         e_speed = 0; e_valid = 0; e_moving = 0; e_dist = 0; e_sat = 0;
         mdl_live = 1'b1;
      end else begin
         t++;
         gap++;
         rise = samp[1] && !samp[0];
         acc  = rise;
`ifdef ODO_DEBOUNCE_EN
         acc  = rise && (gap > DEB);
`endif
         if (acc) gap = 0;
         void'(samp.pop_front());
         samp.push_back(bus.hall_in);
         if (bus.dist_clr) begin
            e_dist = 0;
            e_sat  = 0;
         end
         if (acc) begin
            if (e_dist + DIST_STEP >= DIST_MAX) begin
               e_dist = DIST_MAX;
               e_sat  = 1;
            end else begin
               e_dist += DIST_STEP;
            end
            if (wcnt < SPD_MAX) wcnt++;
         end
         e_valid = 0;
         if (t % W == 0) begin
            void'(hist.pop_front());
            hist.push_back(wcnt);
            sum = 0;
            foreach (hist[i]) sum += hist[i];
            e_speed  = (sum > SPD_MAX) ? SPD_MAX : sum;
            e_moving = (wcnt != 0);
            e_valid  = 1;
            wcnt     = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (mdl_live) begin
         check("speed",       32'(bus.speed),       32'(e_speed));
         check("speed_valid", 32'(bus.speed_valid), 32'(e_valid));
         check("moving",      32'(bus.moving),      32'(e_moving));
         check("distance",    32'(bus.distance),    32'(e_dist));
         check("dist_sat",    32'(bus.dist_sat),    32'(e_sat));
      end
   end

   // Called at a negedge: set inputs for the next edge, then wait past it
   task automatic drive(input bit h, input bit c);
      bus.hall_in  = h;
      bus.dist_clr = c;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      bus.hall_in  = 1'b0;
      bus.dist_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int nv, d0, lvl, len, k;
      reset        = 1'b1;
      bus.hall_in  = 1'b0;
      bus.dist_clr = 1'b0;
      @(negedge clk);

      // Reset state and steady 10-cycle square wave
      do_reset();
      check("rst_speed",    32'(bus.speed),    0);
      check("rst_distance", 32'(bus.distance), 0);
      check("rst_moving",   32'(bus.moving),   0);
      nv = 0;
      for (int i = 1; i <= 8 * W; i++) begin
         drive(((i - 1) % 10) < 5, 1'b0);
         if (bus.speed_valid) begin
            check("steady_speed", 32'(bus.speed), (nv < 3) ? 32'(10 * (nv + 1)) : 32'd40);
            check("steady_moving", 32'(bus.moving), 1);
            nv++;
         end
      end
      check("steady_strobes", 32'(nv), 8);

      // Stop: speed decays by one window at a time
      nv = 0;
      for (int i = 1; i <= 4 * W; i++) begin
         drive(1'b0, 1'b0);
         if (bus.speed_valid) begin
            check("stop_speed", 32'(bus.speed), 32'(30 - 10 * nv));
            check("stop_moving", 32'(bus.moving), 0);
            nv++;
         end
      end
      check("stop_strobes", 32'(nv), 4);

      // Pulse landing exactly in the close cycle belongs to the closing window
      do_reset();
      nv = 0;
      for (int i = 1; i <= 2 * W; i++) begin
         drive((i >= 8) && (((i - 8) % 10) < 5), 1'b0);
         if (bus.speed_valid) begin
            check("boundary_speed", 32'(bus.speed), (nv == 0) ? 32'd10 : 32'd20);
            nv++;
         end
      end
      check("boundary_strobes", 32'(nv), 2);

      // Reset mid-window discards the partial window and restarts the timer
      do_reset();
      for (int i = 1; i <= 50; i++) drive((i <= 40) && (((i - 1) % 8) < 4), 1'b0);
      check("mid_distance", 32'(bus.distance), 5);
      reset       = 1'b1;
      bus.hall_in = 1'b0;
      @(negedge clk);
      check("mid_rst_distance", 32'(bus.distance), 0);
      check("mid_rst_speed",    32'(bus.speed),    0);
      reset = 1'b0;
      k = 0;
      for (int i = 1; i <= 3 * W && k == 0; i++) begin
         drive(1'b0, 1'b0);
         if (bus.speed_valid) k = i;
      end
      check("mid_first_valid_cycle", 32'(k), W);

      // Distance saturation, then clear coincident with a pulse
      do_reset();
      for (int p = 1; p <= 8200; p++) begin
         drive(1'b1, 1'b0);
         drive(1'b1, 1'b0);
         drive(1'b0, 1'b0);
         drive(1'b0, 1'b0);
         if (p == 8190) begin
            check("sat_dist_8190", 32'(bus.distance), 8190);
            check("sat_flag_8190", 32'(bus.dist_sat), 0);
         end
         if (p == 8191) begin
            check("sat_dist_8191", 32'(bus.distance), 8191);
            check("sat_flag_8191", 32'(bus.dist_sat), 1);
         end
      end
      check("sat_dist_end", 32'(bus.distance), 8191);
      check("sat_flag_end", 32'(bus.dist_sat), 1);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      check("clr_pulse_dist", 32'(bus.distance), 1);
      check("clr_pulse_sat",  32'(bus.dist_sat), 0);

      // Glitch three edges after an accepted rise
      repeat (6) drive(1'b0, 1'b0);
      d0 = int'(bus.distance);
      drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0);
      drive(1'b1, 1'b0); drive(1'b1, 1'b0);
      repeat (4) drive(1'b0, 1'b0);
`ifdef ODO_DEBOUNCE_EN
      check("glitch_delta", 32'(int'(bus.distance) - d0), 1);
`else
      check("glitch_delta", 32'(int'(bus.distance) - d0), 2);
`endif

      // Randomized runs of hall levels with occasional clears and one reset
      do_reset();
      lvl = 0;
      for (int r = 0; r < 700; r++) begin
         if (r == 350) do_reset();
         len = int'($urandom_range(1, 7));
         lvl = 1 - lvl;
         repeat (len) drive(lvl[0], $urandom_range(0, 49) == 0);
      end
      repeat (3) drive(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
